// File: rtl/bsg_print_stat_snoop_queue.sv
// bsg_print_stat_snoop_queue
//
// Passive snooper on the host/loader manycore link. It watches accepted
// forward writes. When a write targets one of num_chan_p programmable word
// EPAs, it queues a record of {channel, payload data, cycle stamp}. The
// host/cosim side drains the records with a valid/yumi handshake. The link
// is never driven or backpressured.
//
// Optional feature (macro BSG_PRINT_STAT_SNOOP_SRC_EN): each record also
// carries the packet's source x/y coordinates on src_x_o/src_y_o.
//
// Link word layout (MSB first), identical for both link inputs:
//   fwd_v | fwd_pkt | fwd_ready_and_rev | rev_v | rev_pkt | rev_ready_and_rev
// Forward packet layout (MSB first):
//   addr | data | src_y_cord | src_x_cord | y_cord | x_cord
// Return packet layout (MSB first):
//   load_id | data | y_cord | x_cord
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   loader_link_sif_in_i    link traffic into the loader (read only)
//   loader_link_sif_out_i   link traffic out of the loader (read only)
//   chan_epa_i              word EPA per channel; channel k in slice k
//   chan_en_i               per-channel enable
//   v_o, chan_o, tag_o,
//   cycle_o                 head record of the queue (zero while empty)
//   src_x_o, src_y_o        head record source coordinates (feature only)
//   yumi_i                  consume head record; only legal while v_o=1
//   drop_count_o            saturating count of events lost to a full queue
//   overflow_o              sticky flag: at least one event was dropped
//   clear_drop_i            clears drop_count_o and overflow_o
module bsg_print_stat_snoop_queue #(
  parameter int data_width_p    = 32,
  parameter int addr_width_p    = 28,
  parameter int x_cord_width_p  = 7,
  parameter int y_cord_width_p  = 7,
  parameter int load_id_width_p = 11,
  parameter int num_chan_p      = 4,
  parameter int els_p           = 8,
  parameter int cycle_width_p   = 32,
  parameter int drop_width_p    = 16,
  localparam int fwd_pkt_width_lp  = addr_width_p + data_width_p
                                   + 2*x_cord_width_p + 2*y_cord_width_p,
  localparam int rev_pkt_width_lp  = load_id_width_p + data_width_p
                                   + x_cord_width_p + y_cord_width_p,
  localparam int link_sif_width_lp = fwd_pkt_width_lp + rev_pkt_width_lp + 4,
  localparam int chan_width_lp     = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [link_sif_width_lp-1:0]         loader_link_sif_in_i,
  input  logic [link_sif_width_lp-1:0]         loader_link_sif_out_i,
  input  logic [num_chan_p*addr_width_p-1:0]   chan_epa_i,
  input  logic [num_chan_p-1:0]                chan_en_i,
  output logic                                 v_o,
  output logic [chan_width_lp-1:0]             chan_o,
  output logic [data_width_p-1:0]              tag_o,
  output logic [cycle_width_p-1:0]             cycle_o,
`ifdef BSG_PRINT_STAT_SNOOP_SRC_EN
  output logic [x_cord_width_p-1:0]            src_x_o,
  output logic [y_cord_width_p-1:0]            src_y_o,
`endif
  input  logic                                 yumi_i,
  output logic [drop_width_p-1:0]              drop_count_o,
  output logic                                 overflow_o,
  input  logic                                 clear_drop_i
);

  localparam int ptr_width_lp   = $clog2(els_p);
  localparam int count_width_lp = $clog2(els_p + 1);
  localparam int fwd_pkt_lsb_lp = rev_pkt_width_lp + 3;
  localparam int src_x_lsb_lp   = x_cord_width_p + y_cord_width_p;
  localparam int src_y_lsb_lp   = 2*x_cord_width_p + y_cord_width_p;
  localparam int data_lsb_lp    = 2*x_cord_width_p + 2*y_cord_width_p;
  localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] full_cnt_lp = count_width_lp'(els_p);

  logic                        fwd_v;
  logic                        fwd_ready;
  logic [fwd_pkt_width_lp-1:0] fwd_pkt;
  logic [addr_width_p-1:0]     pkt_addr;
  logic [data_width_p-1:0]     pkt_data;
  logic [x_cord_width_p-1:0]   pkt_src_x;
  logic [y_cord_width_p-1:0]   pkt_src_y;

  // The forward valid and packet come from traffic heading into the
  // loader; the acceptance handshake comes from the loader's side.
  assign fwd_v     = loader_link_sif_in_i[link_sif_width_lp-1];
  assign fwd_pkt   = loader_link_sif_in_i[fwd_pkt_lsb_lp +: fwd_pkt_width_lp];
  assign fwd_ready = loader_link_sif_out_i[rev_pkt_width_lp + 2];
  assign pkt_addr  = fwd_pkt[fwd_pkt_width_lp-1 -: addr_width_p];
  assign pkt_data  = fwd_pkt[data_lsb_lp +: data_width_p];
  assign pkt_src_x = fwd_pkt[src_x_lsb_lp +: x_cord_width_p];
  assign pkt_src_y = fwd_pkt[src_y_lsb_lp +: y_cord_width_p];

  // Most link bits are irrelevant to the snooper; folding them here keeps
  // them visibly consumed.
  logic unused_link;
  assign unused_link = ^{loader_link_sif_in_i, loader_link_sif_out_i};

  logic                     hit;
  logic [chan_width_lp-1:0] hit_chan;

  // Channel match. The scan runs from the highest index down so that the
  // lowest matching channel is the one left in hit_chan.
  always_comb begin
    hit      = 1'b0;
    hit_chan = '0;
    for (int k = num_chan_p - 1; k >= 0; k--) begin
      if (chan_en_i[k] && (pkt_addr == chan_epa_i[k*addr_width_p +: addr_width_p])) begin
        hit      = 1'b1;
        hit_chan = k[chan_width_lp-1:0];
      end
    end
  end

  logic [ptr_width_lp-1:0]   wr_ptr, rd_ptr;
  logic [count_width_lp-1:0] count;
  logic [cycle_width_p-1:0]  cycle_cnt;
  logic                      fire, empty, full, pop, push, drop;

  assign fire  = fwd_v & fwd_ready & hit;
  assign empty = (count == '0);
  assign full  = (count == full_cnt_lp);
  assign pop   = yumi_i & ~empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push  = fire & (~full | pop);
  assign drop  = fire & full & ~pop;

  // Queue pointers and occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == last_ptr_lp) ? '0 : wr_ptr + ptr_width_lp'(1);
      if (pop)  rd_ptr <= (rd_ptr == last_ptr_lp) ? '0 : rd_ptr + ptr_width_lp'(1);
      if (push && !pop)      count <= count + count_width_lp'(1);
      else if (pop && !push) count <= count - count_width_lp'(1);
    end
  end

  // Free-running cycle stamp; wraps silently.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cycle_cnt <= '0;
    else         cycle_cnt <= cycle_cnt + cycle_width_p'(1);
  end

  // Drop accounting. A clear and a drop in the same cycle leave a count of
  // one, since the clear is applied first.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_count_o <= '0;
      overflow_o   <= 1'b0;
    end else if (clear_drop_i) begin
      drop_count_o <= drop ? drop_width_p'(1) : '0;
      overflow_o   <= drop;
    end else if (drop) begin
      if (~&drop_count_o) drop_count_o <= drop_count_o + drop_width_p'(1);
      overflow_o <= 1'b1;
    end
  end

  logic [chan_width_lp-1:0] chan_mem  [els_p];
  logic [data_width_p-1:0]  tag_mem   [els_p];
  logic [cycle_width_p-1:0] cycle_mem [els_p];

  // Record storage needs no reset: every read is masked while the queue
  // is empty, and reset empties the queue.
  always_ff @(posedge clk_i) begin
    if (push) begin
      chan_mem[wr_ptr]  <= hit_chan;
      tag_mem[wr_ptr]   <= pkt_data;
      cycle_mem[wr_ptr] <= cycle_cnt;
    end
  end

  assign v_o     = ~empty;
  assign chan_o  = v_o ? chan_mem[rd_ptr]  : '0;
  assign tag_o   = v_o ? tag_mem[rd_ptr]   : '0;
  assign cycle_o = v_o ? cycle_mem[rd_ptr] : '0;

`ifdef BSG_PRINT_STAT_SNOOP_SRC_EN
  logic [x_cord_width_p-1:0] src_x_mem [els_p];
  logic [y_cord_width_p-1:0] src_y_mem [els_p];

  // Source coordinates travel with the rest of the record.
  always_ff @(posedge clk_i) begin
    if (push) begin
      src_x_mem[wr_ptr] <= pkt_src_x;
      src_y_mem[wr_ptr] <= pkt_src_y;
    end
  end

  assign src_x_o = v_o ? src_x_mem[rd_ptr] : '0;
  assign src_y_o = v_o ? src_y_mem[rd_ptr] : '0;
`else
  logic unused_src;
  assign unused_src = ^{pkt_src_x, pkt_src_y};
`endif

endmodule

// File: tb/tb_bsg_print_stat_snoop_queue.sv
// Self-checking bench for bsg_print_stat_snoop_queue. Directed table
// vectors, hand-written multi-cycle sequences and randomized traffic are
// all compared against a queue-based reference model.
module tb_bsg_print_stat_snoop_queue;

  localparam int D = 16, A = 8, X = 4, Y = 4, L = 4;
  localparam int N = 4, E = 8, C = 8, W = 3;
  localparam int FWD_W  = A + D + 2*X + 2*Y;
  localparam int REV_W  = L + D + X + Y;
  localparam int LINK_W = FWD_W + REV_W + 4;
  localparam int PKT_LSB = REV_W + 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [LINK_W-1:0] link_in = '0;
  logic [LINK_W-1:0] link_out = '0;
  logic [N*A-1:0]    chan_epa;
  logic [N-1:0]      chan_en = '0;
  logic              yumi = 1'b0;
  logic              clear_drop = 1'b0;
  logic              v;
  logic [1:0]        chan;
  logic [D-1:0]      tag;
  logic [C-1:0]      cycle;
  logic [W-1:0]      drop_count;
  logic              overflow;
`ifdef BSG_PRINT_STAT_SNOOP_SRC_EN
  logic [X-1:0]      src_x;
  logic [Y-1:0]      src_y;
`endif

  bsg_print_stat_snoop_queue #(
    .data_width_p(D), .addr_width_p(A), .x_cord_width_p(X), .y_cord_width_p(Y),
    .load_id_width_p(L), .num_chan_p(N), .els_p(E), .cycle_width_p(C),
    .drop_width_p(W)
  ) dut (
    .clk_i(clock),
    .reset_i(reset),
    .loader_link_sif_in_i(link_in),
    .loader_link_sif_out_i(link_out),
    .chan_epa_i(chan_epa),
    .chan_en_i(chan_en),
    .v_o(v),
    .chan_o(chan),
    .tag_o(tag),
    .cycle_o(cycle),
`ifdef BSG_PRINT_STAT_SNOOP_SRC_EN
    .src_x_o(src_x),
    .src_y_o(src_y),
`endif
    .yumi_i(yumi),
    .drop_count_o(drop_count),
    .overflow_o(overflow),
    .clear_drop_i(clear_drop)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   chan;
    logic [D-1:0] tag;
    logic [C-1:0] cyc;
    logic [X-1:0] sx;
    logic [Y-1:0] sy;
  } rec_t;

  rec_t        mq[$];
  int unsigned mcnt;
  int unsigned mdrop;
  bit          movf;
  int          tests = 0;
  int          failed = 0;

  logic [A-1:0] epa [N];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: pop first, then clear, then the event, then the cycle stamp
  // advances. Events go into the queue while it has room, otherwise they
  // are counted as drops (saturating at 2^W-1).
  task automatic modelStep(input logic fv, input logic rdy, input logic [A-1:0] addr,
                           input logic [D-1:0] data, input logic [X-1:0] sx,
                           input logic [Y-1:0] sy, input logic y, input logic clr);
    int hitk;
    rec_t r;
    hitk = -1;
    for (int k = 0; k < N; k++)
      if (hitk < 0 && chan_en[k] && addr == epa[k]) hitk = k;
    if (y && mq.size() > 0) void'(mq.pop_front());
    if (clr) begin
      mdrop = 0;
      movf  = 0;
    end
    if (fv && rdy && hitk >= 0) begin
      if (mq.size() < E) begin
        r.chan = 2'(hitk);
        r.tag  = data;
        r.cyc  = C'(mcnt);
        r.sx   = sx;
        r.sy   = sy;
        mq.push_back(r);
      end else begin
        if (mdrop < (1 << W) - 1) mdrop++;
        movf = 1;
      end
    end
    mcnt = (mcnt + 1) % (1 << C);
  endtask

  // Drives one cycle of link traffic, advances the model, and returns one
  // time unit after the rising edge.
  task automatic applyStimulus(input logic fv, input logic rdy, input logic [A-1:0] addr,
                               input logic [D-1:0] data, input logic y, input logic clr);
    logic [95:0]  r;
    logic [X-1:0] sx;
    logic [Y-1:0] sy;
    sx = X'($urandom());
    sy = Y'($urandom());
    r = {$urandom(), $urandom(), $urandom()};
    link_in = r[LINK_W-1:0];
    link_in[LINK_W-1] = fv;
    link_in[PKT_LSB + FWD_W - 1 -: A] = addr;
    link_in[PKT_LSB + 2*X + 2*Y +: D] = data;
    link_in[PKT_LSB + X + Y +: X] = sx;
    link_in[PKT_LSB + 2*X + Y +: Y] = sy;
    r = {$urandom(), $urandom(), $urandom()};
    link_out = r[LINK_W-1:0];
    link_out[REV_W + 2] = rdy;
    yumi = y;
    clear_drop = clr;
    modelStep(fv, rdy, addr, data, sx, sy, y, clr);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic y);
    applyStimulus(1'b0, 1'($urandom()), A'($urandom()), D'($urandom()), y, 1'b0);
  endtask

  task automatic checkOutput(input string nm);
    check({nm, ".v"}, 32'(v), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check({nm, ".chan"}, 32'(chan), 32'(mq[0].chan));
      check({nm, ".tag"}, 32'(tag), 32'(mq[0].tag));
      check({nm, ".cycle"}, 32'(cycle), 32'(mq[0].cyc));
`ifdef BSG_PRINT_STAT_SNOOP_SRC_EN
      check({nm, ".src_x"}, 32'(src_x), 32'(mq[0].sx));
      check({nm, ".src_y"}, 32'(src_y), 32'(mq[0].sy));
`endif
    end
    check({nm, ".drop"}, 32'(drop_count), mdrop);
    check({nm, ".ovf"}, 32'(overflow), 32'(movf));
  endtask

  task automatic checkZero(input string nm);
    check({nm, ".v"}, 32'(v), 0);
    check({nm, ".chan"}, 32'(chan), 0);
    check({nm, ".tag"}, 32'(tag), 0);
    check({nm, ".cycle"}, 32'(cycle), 0);
    check({nm, ".drop"}, 32'(drop_count), 0);
    check({nm, ".ovf"}, 32'(overflow), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    yumi = 1'b0;
    clear_drop = 1'b0;
    link_in = '0;
    link_out = '0;
    mq.delete();
    mcnt = 0;
    mdrop = 0;
    movf = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] en;
    logic         fv;
    logic         rdy;
    logic [A-1:0] addr;
    logic [D-1:0] data;
    logic         exp_v;
    logic [1:0]   exp_chan;
    logic [D-1:0] exp_tag;
  } vec_t;

  vec_t tbl[8];

  initial begin
    epa[0] = 8'h40; epa[1] = 8'h11; epa[2] = 8'h22; epa[3] = 8'h40;
    chan_epa = {epa[3], epa[2], epa[1], epa[0]};
    chan_en = 4'hF;

    tbl[0] = '{4'hF,    1, 1, 8'h22, 16'hDEAD, 1, 2'd2, 16'hDEAD};
    tbl[1] = '{4'hF,    1, 0, 8'h22, 16'hDEAD, 0, 2'd0, 16'h0};
    tbl[2] = '{4'b1011, 1, 1, 8'h22, 16'hDEAD, 0, 2'd0, 16'h0};
    tbl[3] = '{4'hF,    1, 1, 8'h40, 16'h1234, 1, 2'd0, 16'h1234};
    tbl[4] = '{4'b1010, 1, 1, 8'h40, 16'h5678, 1, 2'd3, 16'h5678};
    tbl[5] = '{4'hF,    0, 1, 8'h11, 16'h9999, 0, 2'd0, 16'h0};
    tbl[6] = '{4'hF,    1, 1, 8'h33, 16'h7777, 0, 2'd0, 16'h0};
    tbl[7] = '{4'b0010, 1, 1, 8'h11, 16'hBEEF, 1, 2'd1, 16'hBEEF};

    doReset();
    checkZero("reset");

    // Single event at counter value 100.
    for (int i = 0; i < 300 && mcnt != 100; i++) idle(1'b0);
    applyStimulus(1'b1, 1'b1, 8'h22, 16'hDEAD, 1'b0, 1'b0);
    check("first.v", 32'(v), 1);
    check("first.chan", 32'(chan), 2);
    check("first.tag", 32'(tag), 32'hDEAD);
    check("first.cycle", 32'(cycle), 100);
    checkOutput("first");
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    check("first_pop.v", 32'(v), 0);

    // Directed vectors: one event, check the record, pop it.
    foreach (tbl[i]) begin
      chan_en = tbl[i].en;
      applyStimulus(tbl[i].fv, tbl[i].rdy, tbl[i].addr, tbl[i].data, 1'b0, 1'b0);
      check($sformatf("vec%0d.v", i), 32'(v), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) begin
        check($sformatf("vec%0d.chan", i), 32'(chan), 32'(tbl[i].exp_chan));
        check($sformatf("vec%0d.tag", i), 32'(tag), 32'(tbl[i].exp_tag));
      end
      checkOutput($sformatf("vec%0d", i));
      idle(mq.size() != 0);
      checkOutput($sformatf("vec%0d_pop", i));
    end
    check("vec.drop", 32'(drop_count), 0);
    chan_en = 4'hF;

    // Ten events into an eight-deep queue: two drops.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 1'b1, 8'h11, 16'h0100 + 16'(i), 1'b0, 1'b0);
    check("ovf.drop", 32'(drop_count), 2);
    check("ovf.flag", 32'(overflow), 1);
    checkOutput("ovf");
    idle(1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b1);
    check("clear.drop", 32'(drop_count), 0);
    check("clear.flag", 32'(overflow), 0);
    applyStimulus(1'b1, 1'b1, 8'h11, 16'h01FF, 1'b1, 1'b0);
    check("fullpop.drop", 32'(drop_count), 0);
    check("fullpop.head", 32'(tag), 32'h0101);
    checkOutput("fullpop");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d.tag", i), 32'(tag), (i < 7) ? 32'h0101 + 32'(i) : 32'h01FF);
      idle(1'b1);
    end
    check("drain.v", 32'(v), 0);

    // Saturation of the drop counter, then clear colliding with a drop.
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'b1, 8'h22, 16'(i), 1'b0, 1'b0);
    check("sat.drop", 32'(drop_count), 7);
    checkOutput("sat");
    applyStimulus(1'b1, 1'b1, 8'h22, 16'hAAAA, 1'b0, 1'b1);
    check("clrdrop.drop", 32'(drop_count), 1);
    check("clrdrop.flag", 32'(overflow), 1);
    checkOutput("clrdrop");
    for (int i = 0; i < 8; i++) idle(1'b1);
    checkOutput("sat_drain");

    // Cycle stamp wrap.
    for (int i = 0; i < 300 && mcnt != 255; i++) idle(1'b0);
    applyStimulus(1'b1, 1'b1, 8'h22, 16'h00AA, 1'b0, 1'b0);
    check("wrap0.cycle", 32'(cycle), 255);
    idle(1'b0);
    applyStimulus(1'b1, 1'b1, 8'h11, 16'h00BB, 1'b0, 1'b0);
    check("wrap1.cycle", 32'(cycle), 255);
    idle(1'b1);
    check("wrap2.cycle", 32'(cycle), 1);
    checkOutput("wrap");
    idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [A-1:0] a;
      case ($urandom_range(4))
        0: a = 8'h40;
        1: a = 8'h11;
        2: a = 8'h22;
        3: a = 8'h33;
        default: a = A'($urandom());
      endcase
      if (i % 40 == 0) chan_en = N'($urandom());
      applyStimulus($urandom_range(9) < 7, $urandom_range(9) < 7, a, D'($urandom()),
                    (mq.size() != 0) && ($urandom_range(9) < 3), $urandom_range(99) < 3);
      checkOutput($sformatf("rand%0d", i));
    end

    // Asynchronous reset with records queued.
    chan_en = 4'hF;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 8'h11, 16'hC000 + 16'(i), 1'b0, 1'b0);
    check("areset_pre.v", 32'(v), 1);
    #2;
    reset = 1'b1;
    #1;
    checkZero("areset");
    doReset();
    checkOutput("areset_post");
    applyStimulus(1'b1, 1'b1, 8'h40, 16'h4242, 1'b0, 1'b0);
    check("post.cycle", 32'(cycle), 0);
    checkOutput("post");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
